otp_auth_ctrl: RTL and testbench
================================

# otp_auth_ctrl

Authentication sequencer for the OTP token. It requests a fresh OTP from the LFSR and assembles the user's keypad digits into a 16-bit entry. On submit it compares the entry with the LFSR OTP, counts wrong attempts and enforces expiry, unlock and lockout windows. Its `unlock`, `lock`, `expire`, `wrng_att` and `user_otp` outputs drive the OTP/status display controller and the rest of the design.

## Interface
- `EXPIRE_CYCLES`, 100_000_000: cycles an issued OTP stays valid.
- `UNLOCK_CYCLES`, 50_000_000: cycles `unlock` is held after a correct entry.
- `LOCK_CYCLES`, 300_000_000: lockout duration after the final wrong attempt.
- `clk` input 1: system clock; all logic on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `req` input 1: single-cycle pulse requesting a new OTP.
- `digit_in` input 4: keypad digit, BCD 0–9.
- `digit_vld` input 1: single-cycle strobe qualifying `digit_in`.
- `clr` input 1: discard the current entry.
- `submit` input 1: single-cycle pulse to check the entry.
- `lfsr_otp` input 16: current LFSR OTP, 4 BCD nibbles; stable except after `gen_otp`.
- `gen_otp` output 1: single-cycle pulse telling the LFSR to advance.
- `user_otp` output 16: entered digits, newest in [3:0].
- `unlock` output 1: correct OTP window.
- `lock` output 1: lockout window.
- `expire` output 1: OTP expired.
- `wrng_att` output 2: wrong attempts since the last clear, 0–3.

## Operation
- States: IDLE, ARMED, UNLOCK, LOCKOUT, EXPIRED.
- IDLE:
  - `req` → pulse `gen_otp`, load timer with EXPIRE_CYCLES−1, clear entry and digit count, go to ARMED.
  - Other inputs are ignored.
- ARMED, entry:
  - `digit_vld` with `digit_in`≤9 → `user_otp` <= {`user_otp`[11:0], `digit_in`}; digit count increments and saturates at 4.
  - Digits above 9 are ignored.
  - Entering more than 4 digits keeps the last 4.
  - `clr` → `user_otp`=0, count=0.
- ARMED, `submit`:
  - Match requires count==4 and `user_otp`==`lfsr_otp`, with `lfsr_otp` sampled in the `submit` cycle.
  - Match → go to UNLOCK, load timer with UNLOCK_CYCLES−1, `wrng_att`=0.
  - Mismatch, including fewer than 4 digits → `wrng_att`+1 and entry cleared.
  - If the new `wrng_att`==3 → go to LOCKOUT with timer = LOCK_CYCLES−1. Otherwise stay in ARMED and keep the expiry timer running.
- ARMED, timeout: timer reaches 0 → go to EXPIRED, clear entry.
- ARMED priority in one cycle: `submit` > timeout > `clr` > `digit_vld`. The lower-priority events in that cycle are dropped.
- UNLOCK: timer reaches 0 → go to IDLE, clear entry.
- LOCKOUT:
  - Timer reaches 0 → go to IDLE, `wrng_att`=0, clear entry.
  - `req` is ignored.
- EXPIRED:
  - `req` → behaves exactly as `req` in IDLE (new OTP, ARMED).
  - `wrng_att` is preserved across expiry.
- `req` is ignored in ARMED and UNLOCK.
- Outputs are Moore, decoded from registered state: `unlock`=UNLOCK, `lock`=LOCKOUT, `expire`=EXPIRED. At most one of the three is high.

## Timing
- Reset values: state IDLE, `user_otp`=0, `wrng_att`=0, `gen_otp`/`unlock`/`lock`/`expire`=0, timer=0, count=0.
- Reset takes effect asynchronously at any point, including mid-window.
- `req` in cycle N → `gen_otp` high in cycle N+1 only; state is ARMED from N+1.
- `digit_vld` in N → `user_otp` updated in N+1.
- `submit` in N → `unlock`, `lock` or the new `wrng_att` visible in N+1.
- Window lengths:
  - ARMED with no submit lasts exactly EXPIRE_CYCLES cycles; `expire` rises on cycle EXPIRE_CYCLES after entry.
  - `unlock` is high exactly UNLOCK_CYCLES cycles.
  - `lock` is high exactly LOCK_CYCLES cycles.
- Timer width is $clog2 of the largest parameter. It is a down-counter; the load value is the parameter minus 1.
- All parameters must be ≥1; a value of 1 gives a 1-cycle window.
- The LFSR must hold `lfsr_otp` from `gen_otp`+1 until the next `gen_otp`.

## Structure
- Package `otp_auth_pkg`:
  - state enum `auth_state_t`.
  - `MAX_ATT`=3.
  - `OTP_DIGITS`=4.
  - `DIGIT_W`=4.
  - BCD maximum 9.
- Sub-module `otp_win_timer`:
  - Loadable down-counter with `load`, `load_val` and a `zero` flag.
  - One instance, shared by the ARMED, UNLOCK and LOCKOUT windows.

## Test plan
- Correct entry (small params, e.g. 20/5/10): `req`; `lfsr_otp`=16'h4821; digits 4,8,2,1; `submit` → `unlock`=1 for 5 cycles, `wrng_att`=0, then IDLE.
- Three wrong submits (16'h1111 vs 16'h4821) → `wrng_att` steps 1, 2, then `lock`=1 for 10 cycles with `wrng_att`=3; `req` during lockout gives no `gen_otp`; afterwards `wrng_att`=0.
- No submit → `expire`=1 exactly 20 cycles after entering ARMED; `req` → single `gen_otp` pulse and a fresh 20-cycle window; `wrng_att` retained.
- Short entry: 3 digits then `submit` → counted as wrong, `wrng_att`=1. Digit 4'hB ignored. 5 digits 9,4,8,2,1 → `user_otp`=16'h4821.
- Simultaneous events: `submit` on the timeout cycle is evaluated and no expire occurs; `digit_vld` together with `submit` drops the digit; `clr` together with `digit_vld` gives `user_otp`=0.
- Assert `rstn` low mid-UNLOCK and mid-LOCKOUT → all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/otp_auth_pkg.sv
// Shared types and constants for the OTP authentication sequencer.
package otp_auth_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_UNLOCK  = 3'd2,
    S_LOCKOUT = 3'd3,
    S_EXPIRED = 3'd4
  } auth_state_t;

  localparam int MAX_ATT    = 3;
  localparam int OTP_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int OTP_W      = OTP_DIGITS * DIGIT_W;
  localparam int CNT_W      = 3;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/otp_win_timer.sv
// Loadable down-counter shared by the expiry, unlock and lockout windows.
module otp_win_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/otp_auth_ctrl.sv
// OTP authentication sequencer: digit entry, compare, attempt counting and timed windows.
module otp_auth_ctrl
  import otp_auth_pkg::*;
#(
  parameter int EXPIRE_CYCLES = 100_000_000,
  parameter int UNLOCK_CYCLES = 50_000_000,
  parameter int LOCK_CYCLES   = 300_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [3:0]  digit_in,
  input  logic        digit_vld,
  input  logic        clr,
  input  logic        submit,
  input  logic [15:0] lfsr_otp,
  output logic        gen_otp,
  output logic [15:0] user_otp,
  output logic        unlock,
  output logic        lock,
  output logic        expire,
  output logic [1:0]  wrng_att
);

  localparam int MAX_CYC_EU = (EXPIRE_CYCLES > UNLOCK_CYCLES) ? EXPIRE_CYCLES : UNLOCK_CYCLES;
  localparam int MAX_CYC    = (MAX_CYC_EU > LOCK_CYCLES) ? MAX_CYC_EU : LOCK_CYCLES;
  localparam int TW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] EXP_LOAD = TW'(EXPIRE_CYCLES - 1);
  localparam logic [TW-1:0] UNL_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LCK_LOAD = TW'(LOCK_CYCLES - 1);

  auth_state_t      state_reg, state_next;
  logic [OTP_W-1:0] user_reg, user_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       att_reg, att_next;
  logic             gen_reg, gen_next;
  logic [1:0]       att_inc;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  otp_win_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
      user_reg  <= '0;
      cnt_reg   <= '0;
      att_reg   <= '0;
      gen_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      user_reg  <= user_next;
      cnt_reg   <= cnt_next;
      att_reg   <= att_next;
      gen_reg   <= gen_next;
    end
  end

  assign att_inc = att_reg + 2'd1;

  always_comb begin
    state_next = state_reg;
    user_next  = user_reg;
    cnt_next   = cnt_reg;
    att_next   = att_reg;
    gen_next   = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_reg)
      S_IDLE, S_EXPIRED: begin
        if (req) begin
          gen_next   = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = EXP_LOAD;
          user_next  = '0;
          cnt_next   = '0;
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        // Priority: submit, then timeout, then clear, then digit entry.
        if (submit) begin
          if (cnt_reg == CNT_W'(OTP_DIGITS) && user_reg == lfsr_otp) begin
            state_next = S_UNLOCK;
            tmr_load   = 1'b1;
            tmr_val    = UNL_LOAD;
            att_next   = '0;
          end else begin
            att_next  = att_inc;
            user_next = '0;
            cnt_next  = '0;
            if (att_inc == 2'(MAX_ATT)) begin
              state_next = S_LOCKOUT;
              tmr_load   = 1'b1;
              tmr_val    = LCK_LOAD;
            end
          end
        end else if (tmr_zero) begin
          state_next = S_EXPIRED;
          user_next  = '0;
          cnt_next   = '0;
        end else if (clr) begin
          user_next = '0;
          cnt_next  = '0;
        end else if (digit_vld && is_bcd(digit_in)) begin
          user_next = {user_reg[OTP_W-DIGIT_W-1:0], digit_in};
          if (cnt_reg < CNT_W'(OTP_DIGITS)) begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      S_UNLOCK: begin
        if (tmr_zero) begin
          state_next = S_IDLE;
          user_next  = '0;
          cnt_next   = '0;
        end
      end
      S_LOCKOUT: begin
        if (tmr_zero) begin
          state_next = S_IDLE;
          att_next   = '0;
          user_next  = '0;
          cnt_next   = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign gen_otp  = gen_reg;
  assign user_otp = user_reg;
  assign wrng_att = att_reg;
  assign unlock   = (state_reg == S_UNLOCK);
  assign lock     = (state_reg == S_LOCKOUT);
  assign expire   = (state_reg == S_EXPIRED);

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Self-checking bench for otp_auth_ctrl with short windows (20/5/10 cycles).
module tb_otp_auth_ctrl;

  localparam int EXP_C = 20;
  localparam int UNL_C = 5;
  localparam int LCK_C = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_vld = 1'b0;
  logic        clr = 1'b0;
  logic        submit = 1'b0;
  logic [15:0] lfsr_otp = 16'h4821;
  logic        gen_otp;
  logic [15:0] user_otp;
  logic        unlock;
  logic        lock;
  logic        expire;
  logic [1:0]  wrng_att;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  otp_auth_ctrl #(
    .EXPIRE_CYCLES (EXP_C),
    .UNLOCK_CYCLES (UNL_C),
    .LOCK_CYCLES   (LCK_C)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .digit_in  (digit_in),
    .digit_vld (digit_vld),
    .clr       (clr),
    .submit    (submit),
    .lfsr_otp  (lfsr_otp),
    .gen_otp   (gen_otp),
    .user_otp  (user_otp),
    .unlock    (unlock),
    .lock      (lock),
    .expire    (expire),
    .wrng_att  (wrng_att)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       vld;
    logic [3:0] dig;
    logic       clr;
    logic [15:0] exp_user;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic pulse_req();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic enter_digits(input logic [15:0] v, input int ndig);
    for (int i = ndig - 1; i >= 0; i--) begin
      digit_vld = 1'b1;
      digit_in  = v[i*4 +: 4];
      step();
    end
    digit_vld = 1'b0;
  endtask

  task automatic pulse_submit();
    submit = 1'b1;
    step();
    submit = 1'b0;
  endtask

  task automatic wait_unlock_end(output int n);
    n = 0;
    while (unlock && n < 50) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    int c0;
    logic seen_gen;

    // Reset state
    step();
    step();
    chk("rst_outputs", {gen_otp, unlock, lock, expire, wrng_att}, 32'd0);
    chk("rst_user_otp", user_otp, 16'h0000);
    #3 rstn = 1'b1;
    step();
    chk("idle_ignores_digit_pre", user_otp, 16'h0000);

    // IDLE ignores digits; req gives a single gen_otp pulse
    digit_vld = 1'b1; digit_in = 4'd7;
    step();
    digit_vld = 1'b0;
    chk("idle_digit_ignored", user_otp, 16'h0000);
    pulse_req();
    chk("gen_otp_pulse", gen_otp, 1'b1);
    step();
    chk("gen_otp_single", gen_otp, 1'b0);

    // Table-driven entry vectors with scoreboard
    vecs[0] = '{1'b1, 4'd9, 1'b0, 16'h0009};
    vecs[1] = '{1'b1, 4'd4, 1'b0, 16'h0094};
    vecs[2] = '{1'b1, 4'hB, 1'b0, 16'h0094};
    vecs[3] = '{1'b1, 4'd7, 1'b1, 16'h0000};
    vecs[4] = '{1'b1, 4'd9, 1'b0, 16'h0009};
    vecs[5] = '{1'b1, 4'd4, 1'b0, 16'h0094};
    vecs[6] = '{1'b1, 4'd8, 1'b0, 16'h0948};
    vecs[7] = '{1'b1, 4'd2, 1'b0, 16'h9482};
    vecs[8] = '{1'b1, 4'd1, 1'b0, 16'h4821};
    vecs[9] = '{1'b0, 4'd3, 1'b0, 16'h4821};
    for (int i = 0; i < 10; i++) begin
      digit_vld = vecs[i].vld;
      digit_in  = vecs[i].dig;
      clr       = vecs[i].clr;
      exp_q.push_back(vecs[i].exp_user);
      step();
      $display("vec %0d: vld=%b dig=%h clr=%b -> user_otp=%h", i, vecs[i].vld, vecs[i].dig, vecs[i].clr, user_otp);
      chk($sformatf("entry_vec%0d", i), user_otp, exp_q.pop_front());
    end
    digit_vld = 1'b0; clr = 1'b0;

    // Correct submit with a simultaneous digit (digit dropped)
    submit = 1'b1; digit_vld = 1'b1; digit_in = 4'd5;
    step();
    submit = 1'b0; digit_vld = 1'b0;
    chk("match_unlock", unlock, 1'b1);
    chk("match_att", wrng_att, 2'd0);
    chk("submit_drops_digit", user_otp, 16'h4821);
    wait_unlock_end(n);
    chk("unlock_len", n, UNL_C);
    chk("after_unlock_idle", {unlock, lock, expire}, 3'b000);
    chk("after_unlock_user", user_otp, 16'h0000);

    // Three wrong submits -> lockout
    pulse_req();
    for (int a = 1; a <= 3; a++) begin
      enter_digits(16'h1111, 4);
      pulse_submit();
      chk($sformatf("wrong_att%0d", a), wrng_att, a);
      chk($sformatf("wrong_user%0d", a), user_otp, 16'h0000);
      chk($sformatf("wrong_lock%0d", a), lock, (a == 3) ? 1'b1 : 1'b0);
    end
    n = 0; seen_gen = 1'b0;
    while (lock && n < 100) begin
      n++;
      req = 1'b1;
      step();
      if (gen_otp) seen_gen = 1'b1;
    end
    req = 1'b0;
    chk("lock_len", n, LCK_C);
    chk("lock_req_ignored", seen_gen, 1'b0);
    chk("after_lock_att", wrng_att, 2'd0);
    chk("after_lock_state", {unlock, lock, expire}, 3'b000);

    // Short entry, req in ARMED ignored, expiry timing
    pulse_req();
    c0 = cyc;
    enter_digits(16'h0482, 3);
    pulse_submit();
    chk("short_entry_att", wrng_att, 2'd1);
    req = 1'b1;
    step();
    req = 1'b0;
    chk("armed_req_ignored", gen_otp, 1'b0);
    while (!expire && (cyc - c0) < 200) step();
    chk("expire_time", cyc - c0, EXP_C);
    chk("expire_att_kept", wrng_att, 2'd1);
    chk("expire_user_clr", user_otp, 16'h0000);
    pulse_req();
    c0 = cyc;
    chk("reissue_gen", gen_otp, 1'b1);
    chk("reissue_armed", expire, 1'b0);
    step();
    chk("reissue_gen_single", gen_otp, 1'b0);
    while (!expire && (cyc - c0) < 200) step();
    chk("expire_time2", cyc - c0, EXP_C);
    chk("expire_att_kept2", wrng_att, 2'd1);

    // Submit on the timeout cycle wins over expiry
    pulse_req();
    c0 = cyc;
    enter_digits(16'h4821, 4);
    while ((cyc - c0) < EXP_C - 1) step();
    chk("timeout_cycle_not_expired", expire, 1'b0);
    pulse_submit();
    chk("timeout_submit_unlock", unlock, 1'b1);
    chk("timeout_submit_no_expire", expire, 1'b0);
    chk("timeout_submit_att", wrng_att, 2'd0);
    wait_unlock_end(n);
    chk("unlock_len2", n, UNL_C);

    // Async reset mid-UNLOCK
    pulse_req();
    enter_digits(16'h4821, 4);
    pulse_submit();
    step();
    chk("pre_rst_unlock", unlock, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_unlock", {gen_otp, unlock, lock, expire, wrng_att, user_otp}, 32'd0);
    #2 rstn = 1'b1;
    step();
    chk("post_rst_idle", {unlock, lock, expire}, 3'b000);

    // Async reset mid-LOCKOUT
    pulse_req();
    for (int a = 0; a < 3; a++) begin
      enter_digits(16'h1111, 4);
      pulse_submit();
    end
    step();
    chk("pre_rst_lock", lock, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_lock", {gen_otp, unlock, lock, expire, wrng_att, user_otp}, 32'd0);
    #2 rstn = 1'b1;
    step();
    chk("post_rst2_idle", {unlock, lock, expire}, 3'b000);
    pulse_req();
    chk("post_rst2_req", gen_otp, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
